// File: rtl/sync_fifo_buf.sv
// ----------------------------------------------------------------------------
// sync_fifo_buf
// Single-clock FIFO with integrated storage, pointers, occupancy count and
// status flags. Read timing is either a registered read (FWFT=0) or
// first-word-fall-through (FWFT=1), where an output register holds the head.
//
// Ports
//   clk            clock, all state on rising edge
//   rst_n          asynchronous active-low reset
//   winc / wdata   write request and data
//   rinc           read request (pop)
//   rdata          registered read data
//   wfull          count == DEPTH
//   rempty         FIFO empty / no valid rdata
//   walmost_full   count >= AFULL_THRESH
//   ralmost_empty  count <= AEMPTY_THRESH
//   count          words held, 0..DEPTH (includes FWFT output register)
//   overflow       sticky: write attempted while full
//   underflow      sticky: read attempted while empty
// ----------------------------------------------------------------------------
module sync_fifo_buf #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  walmost_full,
    output logic                  ralmost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ov_q, ov_d;     // output register holds a valid word
    logic                  of_q, of_d;
    logic                  uf_q, uf_d;

    logic wr_acc, rd_acc, arr_empty, ld;

    // Status decoded from registered state only.
    assign count         = count_q;
    assign rdata         = rdata_q;
    assign wfull         = (count_q == DEPTH_C);
    assign rempty        = (FWFT != 0) ? !ov_q : (count_q == '0);
    assign walmost_full  = int'(count_q) >= AFULL_THRESH;
    assign ralmost_empty = int'(count_q) <= AEMPTY_THRESH;
    assign overflow      = of_q;
    assign underflow     = uf_q;

    always_comb begin
        wr_acc = winc && !wfull;
        rd_acc = rinc && !rempty;
        // Words still in the array: count minus the one parked in the
        // output register (ov_q is always 0 in standard mode).
        arr_empty = (count_q == {{ADDR_WIDTH{1'b0}}, ov_q});

        // ld: move mem[rptr] into the output register this edge.
        if (FWFT != 0) begin
            ld = !arr_empty && (rd_acc || !ov_q);
        end else begin
            ld = rd_acc;
        end

        ov_d = ov_q;
        if (FWFT != 0) begin
            if (ld) begin
                ov_d = 1'b1;
            end else if (rd_acc) begin
                ov_d = 1'b0;
            end
        end

        rdata_d = ld ? mem_q[rptr_q] : rdata_q;
        rptr_d  = ld ? rptr_q + PTR_ONE : rptr_q;
        wptr_d  = wr_acc ? wptr_q + PTR_ONE : wptr_q;

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        of_d = of_q || (winc && wfull);
        uf_d = uf_q || (rinc && rempty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
            ov_q    <= 1'b0;
            of_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            ov_q    <= ov_d;
            of_q    <= of_d;
            uf_q    <= uf_d;
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: tb/tb_sync_fifo_buf.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_buf
// Drives a standard-read and an FWFT instance with identical stimulus and
// compares every output after every edge against queue-based reference models.
// ----------------------------------------------------------------------------
module tb_sync_fifo_buf;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic [7:0] rdata_s, rdata_f;
    logic       wfull_s, wfull_f, rempty_s, rempty_f;
    logic       af_s, af_f, ae_s, ae_f;
    logic [4:0] count_s, count_f;
    logic       of_s, of_f, uf_s, uf_f;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [7:0] q_s[$];
    logic [7:0] q_f[$];
    logic [7:0] m_rd_s, m_rd_f;
    bit         m_ov_f, m_of_s, m_uf_s, m_of_f, m_uf_f;

    always #5 clk = ~clk;

    sync_fifo_buf #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(rdata_s), .wfull(wfull_s), .rempty(rempty_s),
        .walmost_full(af_s), .ralmost_empty(ae_s), .count(count_s),
        .overflow(of_s), .underflow(uf_s)
    );

    sync_fifo_buf #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(rdata_f), .wfull(wfull_f), .rempty(rempty_f),
        .walmost_full(af_f), .ralmost_empty(ae_f), .count(count_f),
        .overflow(of_f), .underflow(uf_f)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_s.delete();
        q_f.delete();
        m_rd_s = 8'h00; m_rd_f = 8'h00;
        m_ov_f = 0; m_of_s = 0; m_uf_s = 0; m_of_f = 0; m_uf_f = 0;
    endtask

    // One clock edge of behaviour, from the current model state and inputs.
    task automatic model_edge();
        bit full, empty, wa, ra;
        int arr;
        // standard mode: rdata is the popped word
        full  = (q_s.size() == 16);
        empty = (q_s.size() == 0);
        if (winc && full)  m_of_s = 1;
        if (rinc && empty) m_uf_s = 1;
        if (rinc && !empty) m_rd_s = q_s.pop_front();
        if (winc && !full)  q_s.push_back(wdata);
        // FWFT mode: queue holds every word, head shown once prefetched
        full  = (q_f.size() == 16);
        empty = !m_ov_f;
        arr   = q_f.size() - (m_ov_f ? 1 : 0);
        wa    = winc && !full;
        ra    = rinc && !empty;
        if (winc && full)  m_of_f = 1;
        if (rinc && empty) m_uf_f = 1;
        if (ra) begin
            void'(q_f.pop_front());
            if (arr > 0) begin m_rd_f = q_f[0]; m_ov_f = 1; end
            else m_ov_f = 0;
        end else if (!m_ov_f && arr > 0) begin
            m_rd_f = q_f[0];
            m_ov_f = 1;
        end
        if (wa) q_f.push_back(wdata);
    endtask

    task automatic compare_all();
        chk("s_rdata",  rdata_s,  m_rd_s);
        chk("s_count",  count_s,  q_s.size());
        chk("s_wfull",  wfull_s,  q_s.size() == 16);
        chk("s_rempty", rempty_s, q_s.size() == 0);
        chk("s_afull",  af_s,     q_s.size() >= 14);
        chk("s_aempty", ae_s,     q_s.size() <= 2);
        chk("s_ovf",    of_s,     m_of_s);
        chk("s_unf",    uf_s,     m_uf_s);
        chk("f_rdata",  rdata_f,  m_rd_f);
        chk("f_count",  count_f,  q_f.size());
        chk("f_wfull",  wfull_f,  q_f.size() == 16);
        chk("f_rempty", rempty_f, !m_ov_f);
        chk("f_afull",  af_f,     q_f.size() >= 14);
        chk("f_aempty", ae_f,     q_f.size() <= 2);
        chk("f_ovf",    of_f,     m_of_f);
        chk("f_unf",    uf_f,     m_uf_f);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_s_rdata"},  rdata_s,  0);
        chk({tag, "_s_count"},  count_s,  0);
        chk({tag, "_s_rempty"}, rempty_s, 1);
        chk({tag, "_s_wfull"},  wfull_s,  0);
        chk({tag, "_s_afull"},  af_s,     0);
        chk({tag, "_s_aempty"}, ae_s,     1);
        chk({tag, "_s_flags"},  {of_s, uf_s}, 0);
        chk({tag, "_f_rdata"},  rdata_f,  0);
        chk({tag, "_f_count"},  count_f,  0);
        chk({tag, "_f_rempty"}, rempty_f, 1);
        chk({tag, "_f_wfull"},  wfull_f,  0);
        chk({tag, "_f_flags"},  {of_f, uf_f}, 0);
    endtask

    // Inputs are applied 1ns after an edge; outputs are checked 1ns after.
    task automatic step(input bit w, input logic [7:0] d, input bit r);
        winc  = w;
        wdata = d;
        rinc  = r;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) step(0, 8'h00, 1);
    endtask

    initial begin
        model_reset();
        #1;
        check_reset_values("rst0");
        #7 rst_n = 1'b1;

        // fill 0x00..0x0F
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
        chk("fill_count", count_s, 16);
        chk("fill_full",  wfull_s, 1);
        // write at full is rejected
        step(1, 8'hAA, 0);
        chk("ovf_set", of_s, 1);
        chk("ovf_count", count_s, 16);
        // drain, each word one cycle after its rinc
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, 1);
            chk("drain_s_data", rdata_s, i);
        end
        chk("drain_empty", rempty_s, 1);
        step(0, 8'h00, 1);
        chk("unf_set", uf_s, 1);
        chk("unf_hold", rdata_s, 8'h0F);
        drain();

        // count=8, simultaneous read/write keeps count
        for (int i = 0; i < 8; i++) step(1, 8'($urandom), 0);
        for (int i = 0; i < 10; i++) step(1, 8'($urandom), 1);
        chk("sim_count", count_s, 8);
        // full, simultaneous: read accepted, write rejected
        for (int i = 0; i < 8; i++) step(1, 8'($urandom), 0);
        step(1, 8'h5C, 1);
        chk("full_sim_count", count_s, 15);
        drain();

        // wrap-around: 3 laps of 2:1 then 1:2
        for (int lap = 0; lap < 3; lap++) begin
            for (int k = 0; k < 24; k++) begin
                if (k % 3 != 2) step(1, 8'($urandom), 0);
                else            step(0, 8'h00, 1);
            end
            for (int k = 0; k < 24; k++) begin
                if (k % 3 == 2) step(1, 8'($urandom), 0);
                else            step(0, 8'h00, 1);
            end
        end

        // random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 45));
        drain();

        // FWFT streaming
        step(1, 8'h11, 0);
        chk("fwft_n_count", count_f, 1);
        chk("fwft_n_empty", rempty_f, 1);
        step(0, 8'h00, 0);
        chk("fwft_n1_empty", rempty_f, 0);
        chk("fwft_n1_data",  rdata_f, 8'h11);
        step(1, 8'h22, 0);
        step(1, 8'h33, 0);
        step(0, 8'h00, 1);
        chk("fwft_rd1", rdata_f, 8'h22);
        step(0, 8'h00, 1);
        chk("fwft_rd2", rdata_f, 8'h33);
        step(0, 8'h00, 1);
        chk("fwft_end_empty", rempty_f, 1);
        drain();

        // asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0);
        chk("pre_rst_count", count_s, 5);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("rst_mid");
        model_reset();
        #1 rst_n = 1'b1;
        step(1, 8'h5A, 0);
        step(0, 8'h00, 0);
        chk("post_rst_f_data", rdata_f, 8'h5A);
        step(0, 8'h00, 1);
        chk("post_rst_s_data", rdata_s, 8'h5A);
        chk("post_rst_empty", rempty_s, 1);
        step(0, 8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_buf.md
Name: sync_fifo_buf

Overview:
Single-clock FIFO buffer. It is the parametrised successor of the FIFO storage RAM: it integrates the dual-port array with its own pointers, occupancy count and status flags. Read timing is selectable between a registered read (standard) and first-word-fall-through (FWFT) mode. It also adds programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It serves as the same-domain buffer in datapaths that do not need clock crossing.

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 4, pointer width; DEPTH = 1<<ADDR_WIDTH (power of 2 only)
AFULL_THRESH, (1<<ADDR_WIDTH)-2, walmost_full asserts when count >= this value
AEMPTY_THRESH, 2, ralmost_empty asserts when count <= this value
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
winc  in  1  write request
wdata  in  DATA_WIDTH  write data
rinc  in  1  read request (pop)
rdata  out  DATA_WIDTH  read data, registered
wfull  out  1  FIFO full
rempty  out  1  FIFO empty / no valid rdata
walmost_full  out  1  count >= AFULL_THRESH
ralmost_empty  out  1  count <= AEMPTY_THRESH
count  out  ADDR_WIDTH+1  words held, range 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n low, asynchronous):
  - wptr, rptr and count go to 0.
  - rempty=1, wfull=0, walmost_full=(AFULL_THRESH==0), ralmost_empty=1.
  - overflow=0, underflow=0, rdata=0, internal output-valid=0.
  - Memory contents are not reset.
- Status outputs are decoded from registered state only. There is no combinational path from winc/rinc/wdata to any output.
- Write accepted: winc && !wfull. mem[wptr]<=wdata, and wptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Read accepted: rinc && !rempty. Write/read acceptance uses flags from the current cycle only. A same-cycle write does not rescue a read from empty, and a same-cycle read does not rescue a write to full.
- count update:
  - +1 on accepted write only.
  - -1 on accepted read only.
  - Unchanged when both are accepted or neither is.
  - count never exceeds DEPTH and never underflows.
- wfull = (count==DEPTH).
- Standard mode (FWFT=0):
  - rempty = (count==0).
  - Accepted read at edge N: rdata<=mem[rptr] at edge N, and rptr increments. rdata is valid from edge N until the next accepted read (latency 1).
  - rdata holds its value when no read is accepted.
- FWFT mode (FWFT=1):
  - An output register holds the head word. rempty = !out_valid. count includes the word in the output register.
  - A write into a fully empty FIFO at edge N loads the output register at edge N+1. count=1 after edge N, and rempty falls after edge N+1.
  - Accepted read at edge N: if the array holds another word, it loads into the output register at edge N, so back-to-back reads stream one word per cycle. Otherwise out_valid clears.
  - Refill of the output register occurs whenever out_valid=0 and the array is non-empty.
- overflow sets on (winc && wfull) and underflow sets on (rinc && rempty). Both are sticky until reset. The rejected operation has no other effect.
- Reset mid-operation: all state clears immediately, regardless of any in-flight write or prefetch. The first write after deassertion goes to address 0.
- Thresholds:
  - walmost_full = count >= AFULL_THRESH.
  - ralmost_empty = count <= AEMPTY_THRESH.
  - Both are recomputed each cycle from count.

Test Plan:
- Fill/drain: FWFT=0, DEPTH=16. Write 0x00..0x0F -> wfull=1, count=16, walmost_full=1 from count 14. Read 16 times -> rdata 0x00..0x0F, each one cycle after its rinc, then rempty=1, count=0.
- Overflow/underflow: at full, winc with wdata=0xAA -> overflow=1, count stays 16, data is not stored. Drain fully, then rinc -> underflow=1, rdata unchanged.
- Simultaneous at boundaries: count=8, winc+rinc for 10 cycles -> count stays 8, output order is preserved. At full, winc+rinc -> read accepted, write rejected, count=15, overflow=1.
- Wrap-around: 3 laps of 16 writes/reads interleaved at 2:1 then 1:2 -> rdata matches a reference queue, and pointers wrap without loss.
- FWFT streaming: FWFT=1, write 0x11 at edge N -> rempty=0 and rdata=0x11 after edge N+1. Write 0x22/0x33, then hold rinc 3 cycles -> rdata 0x11, 0x22, 0x33 on consecutive cycles, then rempty=1.
- Async reset mid-operation: with count=5, pulse rst_n low between edges -> all outputs at reset values immediately. Write 0x5A, read -> rdata=0x5A and flags correct.
